lock_controller: RTL and testbench
==================================

// Module: lock_controller
// PURPOSE
//  Sequencer for the keypad combination lock. Accepts one-cycle key pulses from the level-to-pulse
//  converters and collects CODE_LEN-bit attempts. Each attempt is compared whole-word against a
//  programmable code register. Manages unlock hold, failed-attempt lockout, entry timeout and code
//  reprogramming. Drives state_code to the seven-segment decoder.
// PARAMETERS
//  CODE_LEN       5         bits per attempt/code (2..8)
//  DEFAULT_CODE   5'b01011  code register value after reset (first key = MSB)
//  MAX_FAILS      3         consecutive failed attempts that trigger LOCKOUT (1..3)
//  TICK_DIV       20000000  clk_100Mhz cycles per timer tick (5 Hz tick)
//  ENTRY_TICKS    25        ticks of key inactivity before an ENTRY/PROG attempt is abandoned
//  UNLOCK_TICKS   25        ticks OPEN is held
//  LOCKOUT_TICKS  50        ticks LOCKOUT is held
// PORTS
//  clk_100Mhz  in   1         system clock, all logic on rising edge
//  reset       in   1         synchronous, active-high
//  zero        in   1         one-cycle pulse: key '0'
//  one         in   1         one-cycle pulse: key '1'
//  prog_req    in   1         one-cycle pulse: request code reprogramming (honoured only in OPEN)
//  unlocked    out  1         1 while in OPEN
//  alarm       out  1         1 while in LOCKOUT
//  prog_active out  1         1 while in PROG
//  fail_cnt    out  2         consecutive failed attempts, saturates at MAX_FAILS
//  state_code  out  3         encoded state for seven_seg
// BEHAVIOUR
//  - States (state_code): IDLE=0, ENTRY=1, CHECK=2, OPEN=3, PROG=4, LOCKOUT=5. Codes 6/7 -> IDLE.
//  - Reset: state=IDLE, code_reg=DEFAULT_CODE, shift reg=0, bit count=0, fail_cnt=0, timers and
//    prescaler=0. Outputs: unlocked=0, alarm=0, prog_active=0, state_code=0.
//  - Reset mid-operation aborts any attempt or PROG without altering code_reg, except that it
//    restores DEFAULT_CODE.
//  - Outputs are decoded from registered state/counters only; there is no combinational input->output path.
//  - Key valid = zero XOR one. zero&one in the same cycle is ignored: no shift, no timer restart.
//  - Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap. It and the tick timer restart at 0 on
//    every state change and on every valid key in ENTRY/PROG. Timed durations are therefore exactly
//    N*TICK_DIV cycles.
//  - IDLE: a valid key shifts in (bit count=1) -> ENTRY. prog_req is ignored.
//  - ENTRY: each valid key shifts left into shift reg and increments the count. When the key making
//    count==CODE_LEN arrives -> CHECK on the next edge. ENTRY_TICKS with no valid key -> IDLE,
//    with fail_cnt unchanged.
//  - CHECK (exactly 1 cycle, keys ignored): shift==code_reg -> OPEN and fail_cnt=0. Otherwise
//    fail_cnt+1; if the new value==MAX_FAILS -> LOCKOUT, else -> IDLE. Shift reg and count are
//    cleared on exit.
//  - OPEN: keys ignored. prog_req -> PROG. After UNLOCK_TICKS -> IDLE. If prog_req and the expiry
//    occur in the same cycle, prog_req wins.
//  - PROG: collects CODE_LEN valid keys as in ENTRY. On the final key, code_reg<=new word and
//    state -> IDLE. ENTRY_TICKS inactivity -> IDLE with code_reg unchanged. prog_req is ignored.
//  - LOCKOUT: keys and prog_req ignored. After LOCKOUT_TICKS -> IDLE with fail_cnt=0.
//  - Latency: the final key's edge enters CHECK. unlocked (or alarm) is 1 two edges after the final key.
// TESTING (TICK_DIV=4, ENTRY_TICKS=3, UNLOCK_TICKS=2, LOCKOUT_TICKS=3)
//  1. Reset, keys 0,1,0,1,1 -> CHECK 1 cycle, then unlocked=1, state_code=3 for 8 cycles, then
//     IDLE with unlocked=0.
//  2. Keys 1,1,1,1,1 three times -> fail_cnt 1,2, then alarm=1, state_code=5 for 12 cycles, keys
//     ignored meanwhile, then IDLE with fail_cnt=0.
//  3. Keys 0,1 then 12 idle cycles -> IDLE, fail_cnt=0. Correct code afterwards -> unlocked=1.
//  4. Unlock, prog_req, keys 1,0,0,1,0 -> IDLE. Then 0,1,0,1,1 -> fail_cnt=1, and 1,0,0,1,0 -> unlocked.
//  5. zero&one together mid-entry -> no shift. The remaining 3 single keys complete the code ->
//     unlocked.
//  6. Assert reset during PROG after 3 keys -> IDLE, code_reg=01011, outputs 0. Also assert prog_req
//     in IDLE -> no effect.

Source files
------------

// File: rtl/lock_controller.sv
// Keypad combination-lock sequencer: collects CODE_LEN-bit attempts, compares them against a
// programmable code, and handles unlock hold, lockout after repeated failures, entry timeout and reprogramming.
module lock_controller #(
    parameter int unsigned         CODE_LEN      = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = 5'b01011,
    parameter int unsigned         MAX_FAILS     = 3,
    parameter int unsigned         TICK_DIV      = 20000000,
    parameter int unsigned         ENTRY_TICKS   = 25,
    parameter int unsigned         UNLOCK_TICKS  = 25,
    parameter int unsigned         LOCKOUT_TICKS = 50
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       zero,
    input  logic       one,
    input  logic       prog_req,
    output logic       unlocked,
    output logic       alarm,
    output logic       prog_active,
    output logic [1:0] fail_cnt,
    output logic [2:0] state_code
);

    localparam int unsigned TMAX0 = (ENTRY_TICKS > UNLOCK_TICKS) ? ENTRY_TICKS : UNLOCK_TICKS;
    localparam int unsigned TMAX  = (TMAX0 > LOCKOUT_TICKS) ? TMAX0 : LOCKOUT_TICKS;
    localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned CW    = $clog2(CODE_LEN + 1);

    localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ENTRY_LAST  = TW'(ENTRY_TICKS - 1);
    localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_TICKS - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_TICKS - 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(CODE_LEN - 1);
    localparam logic [1:0]    FAIL_MAX    = 2'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_PROG    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          fail_q, fail_d;
    logic [PW-1:0]       presc_q;
    logic [TW-1:0]       tmr_q;
    logic                key_vld, key_rst, tick, tmr_clr;

    // Pressing both keys at once is treated as no key at all.
    assign key_vld = zero ^ one;
    assign tick    = (presc_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        key_rst = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_vld) begin
                    shift_d = {{(CODE_LEN-1){1'b0}}, one};
                    cnt_d   = CW'(1);
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY, S_PROG: begin
                if (key_vld) begin
                    key_rst = 1'b1;
                    shift_d = {shift_q[CODE_LEN-2:0], one};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        if (state_q == S_ENTRY) begin
                            state_d = S_CHECK;
                        end else begin
                            code_d  = {shift_q[CODE_LEN-2:0], one};
                            shift_d = '0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end
                end else if (tick && tmr_q == ENTRY_LAST) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                shift_d = '0;
                cnt_d   = '0;
                if (shift_q == code_q) begin
                    fail_d  = '0;
                    state_d = S_OPEN;
                end else if (fail_q + 2'd1 == FAIL_MAX) begin
                    fail_d  = FAIL_MAX;
                    state_d = S_LOCKOUT;
                end else begin
                    fail_d  = fail_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                // A reprogram request beats an expiring hold in the same cycle.
                if (prog_req)                            state_d = S_PROG;
                else if (tick && tmr_q == UNLOCK_LAST)   state_d = S_IDLE;
            end
            S_LOCKOUT: begin
                if (tick && tmr_q == LOCK_LAST) begin
                    fail_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timers restart on any state change and on each accepted key so durations are exact.
    assign tmr_clr = key_rst || (state_d != state_q) || (state_q == S_IDLE);

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= DEFAULT_CODE;
            shift_q <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset || tmr_clr) begin
            presc_q <= '0;
            tmr_q   <= '0;
        end else if (tick) begin
            presc_q <= '0;
            tmr_q   <= tmr_q + TW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign unlocked    = (state_q == S_OPEN);
    assign alarm       = (state_q == S_LOCKOUT);
    assign prog_active = (state_q == S_PROG);
    assign fail_cnt    = fail_q;
    assign state_code  = state_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios plus a randomized run, all tracked by a
// cycle-count reference model built from the lock's rules (queues and elapsed-cycle counters).
module tb_lock_controller;

    localparam int CL = 5;
    localparam int TD = 4;
    localparam int ET = 3;
    localparam int UT = 2;
    localparam int LT = 3;
    localparam int MF = 3;
    localparam logic [CL-1:0] DEF_CODE = 5'b01011;

    logic       clk = 1'b0;
    logic       reset, zero, one, prog_req;
    logic       unlocked, alarm, prog_active;
    logic [1:0] fail_cnt;
    logic [2:0] state_code;

    int n_checks = 0;
    int n_err    = 0;

    lock_controller #(
        .CODE_LEN(CL), .DEFAULT_CODE(DEF_CODE), .MAX_FAILS(MF), .TICK_DIV(TD),
        .ENTRY_TICKS(ET), .UNLOCK_TICKS(UT), .LOCKOUT_TICKS(LT)
    ) dut (
        .clk_100Mhz(clk), .reset(reset), .zero(zero), .one(one), .prog_req(prog_req),
        .unlocked(unlocked), .alarm(alarm), .prog_active(prog_active),
        .fail_cnt(fail_cnt), .state_code(state_code)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 entry, 2 check, 3 open, 4 prog, 5 lockout.
    int            m_st   = 0;
    logic [CL-1:0] m_code = DEF_CODE;
    bit            m_bits[$];
    int            m_fail = 0;
    int            m_el   = 0;   // cycles spent since the last timer restart

    function automatic logic [CL-1:0] m_word();
        logic [CL-1:0] v = '0;
        foreach (m_bits[i]) v = {v[CL-2:0], m_bits[i]};
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic z, input logic o, input logic p);
        int  nxt = m_st;
        bit  restart = 0;
        bit  key = z ^ o;
        if (r) begin
            m_st = 0; m_code = DEF_CODE; m_bits = {}; m_fail = 0; m_el = 0;
            return;
        end
        case (m_st)
            0: if (key) begin m_bits = {}; m_bits.push_back(o); nxt = 1; end
            1, 4: begin
                if (key) begin
                    m_bits.push_back(o);
                    restart = 1;
                    if (m_bits.size() == CL) begin
                        if (m_st == 1) nxt = 2;
                        else begin m_code = m_word(); m_bits = {}; nxt = 0; end
                    end
                end else if (m_el == ET*TD - 1) begin
                    m_bits = {}; nxt = 0;
                end
            end
            2: begin
                if (m_word() == m_code) begin m_fail = 0; nxt = 3; end
                else begin m_fail++; nxt = (m_fail == MF) ? 5 : 0; end
                m_bits = {};
            end
            3: if (p) nxt = 4; else if (m_el == UT*TD - 1) nxt = 0;
            5: if (m_el == LT*TD - 1) begin m_fail = 0; nxt = 0; end
            default: nxt = 0;
        endcase
        if (nxt != m_st || restart) m_el = 0; else m_el++;
        m_st = nxt;
    endtask

    // Drive one cycle of inputs; returns at the following falling edge.
    task automatic step(input logic z, input logic o, input logic p);
        zero = z; one = o; prog_req = p;
        @(posedge clk);
        model_edge(reset, z, o, p);
        #1; zero = 1'b0; one = 1'b0; prog_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic key(input logic b);
        step(~b, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic key_word(input logic [CL-1:0] w);
        for (int i = CL-1; i >= 0; i--) key(w[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        n_checks++;
        if ({unlocked, alarm, prog_active, fail_cnt, state_code} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {unlocked, alarm, prog_active, fail_cnt, state_code});
        end
    endtask

    task automatic test_unlock();
        int cnt;
        key_word(5'b01011);
        n_checks++;
        if (state_code !== 3'd2 || unlocked !== 1'b0) begin
            n_err++; $display("FAIL unlock_check_state got=%0d/%b exp=2/0", state_code, unlocked);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (unlocked !== 1'b1 || state_code !== 3'd3) begin
            n_err++; $display("FAIL unlock_latency got=%b/%0d exp=1/3", unlocked, state_code);
        end
        cnt = 1;
        for (int i = 0; i < 40 && unlocked === 1'b1; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (unlocked === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != UT*TD) begin
            n_err++; $display("FAIL unlock_hold got=%0d exp=%0d", cnt, UT*TD);
        end
        n_checks++;
        if (state_code !== 3'd0 || unlocked !== 1'b0) begin
            n_err++; $display("FAIL unlock_exit got=%0d/%b exp=0/0", state_code, unlocked);
        end
    endtask

    task automatic test_lockout();
        int cnt;
        for (int a = 1; a <= 2; a++) begin
            key_word(5'b11111);
            step(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (fail_cnt !== 2'(a) || state_code !== 3'd0) begin
                n_err++; $display("FAIL lockout_fail%0d got=%0d/%0d exp=%0d/0", a, fail_cnt, state_code, a);
            end
        end
        key_word(5'b11111);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (alarm !== 1'b1 || state_code !== 3'd5 || fail_cnt !== 2'd3) begin
            n_err++; $display("FAIL lockout_enter got=%b/%0d/%0d exp=1/5/3", alarm, state_code, fail_cnt);
        end
        cnt = 1;
        for (int i = 0; i < 60 && alarm === 1'b1; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom));
            if (alarm === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != LT*TD) begin
            n_err++; $display("FAIL lockout_hold got=%0d exp=%0d", cnt, LT*TD);
        end
        n_checks++;
        if (state_code !== 3'd0 || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL lockout_exit got=%0d/%0d exp=0/0", state_code, fail_cnt);
        end
    endtask

    task automatic test_timeout();
        key(1'b0); key(1'b1);
        idle(ET*TD - 1);
        n_checks++;
        if (state_code !== 3'd1) begin
            n_err++; $display("FAIL timeout_early got=%0d exp=1", state_code);
        end
        idle(1);
        n_checks++;
        if (state_code !== 3'd0 || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL timeout_exit got=%0d/%0d exp=0/0", state_code, fail_cnt);
        end
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_err++; $display("FAIL timeout_then_unlock got=%b exp=1", unlocked);
        end
        idle(UT*TD);
    endtask

    task automatic test_prog();
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (prog_active !== 1'b1 || state_code !== 3'd4) begin
            n_err++; $display("FAIL prog_enter got=%b/%0d exp=1/4", prog_active, state_code);
        end
        key_word(5'b10010);
        n_checks++;
        if (prog_active !== 1'b0 || state_code !== 3'd0) begin
            n_err++; $display("FAIL prog_done got=%b/%0d exp=0/0", prog_active, state_code);
        end
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fail_cnt !== 2'd1 || unlocked !== 1'b0) begin
            n_err++; $display("FAIL prog_old_code got=%0d/%b exp=1/0", fail_cnt, unlocked);
        end
        key_word(5'b10010);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL prog_new_code got=%b/%0d exp=1/0", unlocked, fail_cnt);
        end
        idle(UT*TD);
    endtask

    // prog_req on the last OPEN cycle wins over expiry; PROG then times out leaving the code as is.
    task automatic test_prog_boundary();
        do_reset();
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        idle(UT*TD - 1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (state_code !== 3'd4) begin
            n_err++; $display("FAIL prog_beats_expiry got=%0d exp=4", state_code);
        end
        key(1'b1);
        idle(ET*TD);
        n_checks++;
        if (state_code !== 3'd0 || prog_active !== 1'b0) begin
            n_err++; $display("FAIL prog_timeout got=%0d/%b exp=0/0", state_code, prog_active);
        end
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_err++; $display("FAIL prog_timeout_code_kept got=%b exp=1", unlocked);
        end
        idle(UT*TD);
    endtask

    task automatic test_both_keys();
        do_reset();
        key(1'b0); key(1'b1);
        step(1'b1, 1'b1, 1'b0);
        key(1'b0);
        key(1'b1);
        n_checks++;
        if (state_code !== 3'd1) begin
            n_err++; $display("FAIL both_no_shift got=%0d exp=1", state_code);
        end
        key(1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_err++; $display("FAIL both_unlock got=%b exp=1", unlocked);
        end
        idle(UT*TD);
        key(1'b0);
        idle(6);
        step(1'b1, 1'b1, 1'b0);
        idle(ET*TD - 8);
        n_checks++;
        if (state_code !== 3'd1) begin
            n_err++; $display("FAIL both_timer_early got=%0d exp=1", state_code);
        end
        idle(1);
        n_checks++;
        if (state_code !== 3'd0) begin
            n_err++; $display("FAIL both_no_restart got=%0d exp=0", state_code);
        end
    endtask

    task automatic test_reset_prog();
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        key(1'b1); key(1'b1); key(1'b1);
        do_reset();
        n_checks++;
        if ({unlocked, alarm, prog_active, state_code} !== 6'd0) begin
            n_err++; $display("FAIL reset_in_prog got=%b exp=000000", {unlocked, alarm, prog_active, state_code});
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (state_code !== 3'd0 || prog_active !== 1'b0) begin
            n_err++; $display("FAIL prog_req_idle got=%0d/%b exp=0/0", state_code, prog_active);
        end
        key_word(5'b01011);
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_err++; $display("FAIL reset_default_code got=%b exp=1", unlocked);
        end
        idle(UT*TD);
    endtask

    task automatic test_random();
        bit pend[$];
        int pause = 0;
        logic [CL-1:0] w;
        logic z, o, p;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            z = 1'b0; o = 1'b0; p = ($urandom % 10 == 0);
            if (pend.size() == 0 && $urandom % 4 == 0) begin
                w = ($urandom % 3 == 0) ? m_code : CL'($urandom);
                for (int i = CL-1; i >= 0; i--) pend.push_back(w[i]);
            end
            if ($urandom % 40 == 0) pause = 10 + $urandom % 6;
            if (pause > 0) pause--;
            else if (pend.size() > 0 && $urandom % 8 < 5) begin
                o = pend.pop_front(); z = ~o;
            end else if ($urandom % 16 == 0) begin
                z = 1'b1; o = 1'b1;
            end
            reset = ($urandom % 400 == 0);
            step(z, o, p);
            reset = 1'b0;
            n_checks++;
            if (state_code !== 3'(m_st) || fail_cnt !== 2'(m_fail) || unlocked !== (m_st == 3) ||
                alarm !== (m_st == 5) || prog_active !== (m_st == 4)) begin
                n_err++;
                $display("FAIL random_c%0d got st=%0d fc=%0d u/a/p=%b%b%b exp st=%0d fc=%0d",
                         c, state_code, fail_cnt, unlocked, alarm, prog_active, m_st, m_fail);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; zero = 1'b0; one = 1'b0; prog_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_unlock();
        test_lockout();
        test_timeout();
        test_prog();
        test_prog_boundary();
        test_both_keys();
        do_reset();
        test_reset_prog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
